// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA raster timing generator. Walks a (X,Y) raster that
//   advances on clock edges where the pixel strobe is high. It emits
//   zero-based coordinates, active-video, sync pulses of configurable
//   polarity and line/frame start strobes. Active and the syncs can be
//   delayed by PIPE_DELAY enabled edges to line up with downstream pixel
//   pipelines.
//
// Ports
//   i_Clk          pixel-domain clock
//   i_Reset        synchronous, active-high reset
//   i_Enable       pixel strobe; position advances only when high
//   o_X, o_Y       current column / row (zero-based)
//   o_Active       high inside the visible window (delayed by PIPE_DELAY)
//   o_HSync        horizontal sync, asserted level HS_POL (delayed)
//   o_VSync        vertical sync, asserted level VS_POL (delayed)
//   o_Line_Start   one-clock strobe when X becomes 0
//   o_Frame_Start  one-clock strobe when (X,Y) becomes (0,0)
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int unsigned PIPE_DELAY = 0,
  parameter int unsigned COUNT_W    = 12
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_Enable,
  output logic [COUNT_W-1:0] o_X,
  output logic [COUNT_W-1:0] o_Y,
  output logic               o_Active,
  output logic               o_HSync,
  output logic               o_VSync,
  output logic               o_Line_Start,
  output logic               o_Frame_Start
);

  localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam logic [COUNT_W-1:0] H_LAST = COUNT_W'(H_TOTAL - 1);
  localparam logic [COUNT_W-1:0] V_LAST = COUNT_W'(V_TOTAL - 1);

  // Cleared delay-line stage: {active, hsync, vsync} all deasserted.
  localparam logic [2:0] IDLE = {1'b0, ~HS_POL, ~VS_POL};

  logic [COUNT_W-1:0] pos_x_q, pos_y_q;
  logic [COUNT_W-1:0] pos_x_d, pos_y_d;
  logic [31:0]        nx32, ny32;
  logic               act_d, hs_d, vs_d;

  logic [COUNT_W-1:0] x_q, y_q;
  logic               act_q, hs_q, vs_q;
  logic               ls_q, fs_q;

  // Next raster position.
  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    if (pos_x_q == H_LAST) begin
      pos_x_d = '0;
      if (pos_y_q == V_LAST) pos_y_d = '0;
      else                   pos_y_d = pos_y_q + 1'b1;
    end else begin
      pos_x_d = pos_x_q + 1'b1;
    end
  end

  // Region decode of the next position, done at 32 bits so region bounds
  // equal to 2^COUNT_W compare correctly.
  always_comb begin
    nx32  = 32'(pos_x_d);
    ny32  = 32'(pos_y_d);
    act_d = (nx32 < H_VISIBLE) && (ny32 < V_VISIBLE);
    hs_d  = ((nx32 >= H_SYNC_START) && (nx32 < H_SYNC_END)) ? HS_POL : ~HS_POL;
    vs_d  = ((ny32 >= V_SYNC_START) && (ny32 < V_SYNC_END)) ? VS_POL : ~VS_POL;
  end

  // Internal position parks on the last pixel so the first enabled edge
  // after reset lands on (0,0); visible outputs reset to zero/inactive.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      pos_x_q <= H_LAST;
      pos_y_q <= V_LAST;
      x_q     <= '0;
      y_q     <= '0;
      act_q   <= 1'b0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      ls_q <= 1'b0;
      fs_q <= 1'b0;
      if (i_Enable) begin
        pos_x_q <= pos_x_d;
        pos_y_q <= pos_y_d;
        x_q     <= pos_x_d;
        y_q     <= pos_y_d;
        act_q   <= act_d;
        hs_q    <= hs_d;
        vs_q    <= vs_d;
        ls_q    <= (pos_x_d == '0);
        fs_q    <= (pos_x_d == '0) && (pos_y_d == '0);
      end
    end
  end

  assign o_X           = x_q;
  assign o_Y           = y_q;
  assign o_Line_Start  = ls_q;
  assign o_Frame_Start = fs_q;

  generate
    if (PIPE_DELAY == 0) begin : g_nodelay
      assign o_Active = act_q;
      assign o_HSync  = hs_q;
      assign o_VSync  = vs_q;
    end else begin : g_delay
      logic [2:0] dly_q [PIPE_DELAY];

      always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
          for (int unsigned i = 0; i < PIPE_DELAY; i++) dly_q[i] <= IDLE;
        end else if (i_Enable) begin
          dly_q[0] <= {act_q, hs_q, vs_q};
          for (int unsigned i = 1; i < PIPE_DELAY; i++) dly_q[i] <= dly_q[i-1];
        end
      end

      assign o_Active = dly_q[PIPE_DELAY-1][2];
      assign o_HSync  = dly_q[PIPE_DELAY-1][1];
      assign o_VSync  = dly_q[PIPE_DELAY-1][0];
    end
  endgenerate

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator, successor to the fixed 640x480 sync controller. Produces zero-based pixel coordinates, active-video (DE), sync pulses of configurable polarity, and line/frame start strobes, with a pixel-rate enable and a configurable sync/DE delay. The delay aligns the syncs and DE with downstream pixel pipelines. Sits between the pixel clock domain root and the pattern/colour generators that drive the VGA DAC pins.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of o_HSync (0 = active-low)
- VS_POL, 0, asserted level of o_VSync
- PIPE_DELAY, 0, extra enabled cycles applied to o_HSync/o_VSync/o_Active (0..15)
- COUNT_W, 12, coordinate width; H_TOTAL and V_TOTAL must each be ≤ 2^COUNT_W

Ports:
- i_Clk  in  1  clock
- i_Reset  in  1  synchronous, active-high reset
- i_Enable  in  1  pixel strobe; position advances only on edges where it is 1
- o_X  out  COUNT_W  current column, 0..H_TOTAL-1
- o_Y  out  COUNT_W  current row, 0..V_TOTAL-1
- o_Active  out  1  1 when X < H_VISIBLE and Y < V_VISIBLE
- o_HSync  out  1  horizontal sync
- o_VSync  out  1  vertical sync
- o_Line_Start  out  1  one-clock strobe when X becomes 0
- o_Frame_Start  out  1  one-clock strobe when (X,Y) becomes (0,0)

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise.
- Horizontal regions:
  - visible: 0..H_VISIBLE-1
  - front porch: next H_FRONT
  - sync: next H_SYNC, i.e. H_VISIBLE+H_FRONT .. H_VISIBLE+H_FRONT+H_SYNC-1
  - back porch: the remainder
- Vertical regions are identical in lines. HSync is asserted (=HS_POL) only in the horizontal sync region. VSync is asserted (=VS_POL) for every pixel of every line in the vertical sync region.
- Advance on an enabled edge:
  - X==H_TOTAL-1 → X=0 and Y increments.
  - Y==V_TOTAL-1 at that wrap → Y=0.
  - Otherwise X increments.
- All outputs are registered. They are decoded from the next position, so X, Y, Active, HSync, VSync and the strobes all describe the same position in the same cycle (before PIPE_DELAY).
- PIPE_DELAY > 0: Active, HSync and VSync pass through a shift register that advances only on enabled edges. X, Y and the strobes are not delayed.
- Reset:
  - Internal position is set to (H_TOTAL-1, V_TOTAL-1), so the first enabled edge after release lands on (0,0).
  - Output reset values: o_X=0, o_Y=0, o_Active=0, o_HSync=~HS_POL, o_VSync=~VS_POL, strobes 0.
  - All delay-line stages are cleared to inactive.
- Reset takes priority over i_Enable. Reset mid-frame abandons the frame immediately; no partial-sync completion.

## Timing
- Latency: output update is one clock after the enabled edge that moves the position; no further latency when PIPE_DELAY=0.
- Strobes are high for exactly one i_Clk cycle, after the enabled edge that loads X=0 (Line) or (0,0) (Frame). They clear on the next edge regardless of i_Enable.
- i_Enable=0 holds X, Y, Active, HSync, VSync and the delay line frozen.
- Frame period: H_TOTAL*V_TOTAL enabled edges; 420000 at defaults.
- Line period: H_TOTAL enabled edges.

## Test plan
- Reset 4 cycles, then i_Enable=1 → 1 clock after release: X=0, Y=0, Active=1, Line_Start=1, Frame_Start=1. HSync low exactly for X=656..751 (96 clocks). Line_Start period is 800 clocks.
- Run 2 frames → VSync low only for Y=490..491 (1600 clocks per frame). Frame_Start period is 420000. Active high for 307200 clocks per frame, never for X≥640 or Y≥480.
- i_Enable alternating 1,0 → position advances every other clock; line takes 1600 clocks. Line_Start stays exactly 1 clock wide. Outputs are stable during disabled cycles.
- PIPE_DELAY=3, HS_POL=1, VS_POL=1 → HSync rises when X=659 and falls when X=755. Active falls when X=643. X and strobes are unchanged from the PIPE_DELAY=0 run.
- Assert i_Reset at X=300, Y=200 with i_Enable=1 → next cycle: X=0, Y=0, Active=0, syncs inactive, delay line empty. After release, the first enabled edge gives Frame_Start=1 at (0,0).
- Small params (H 4,1,2,1; V 3,1,1,1) → X cycles 0..7; Y wraps 5→0 on the X 7→0 edge. HSync asserted at X=5,6; VSync asserted throughout Y=4.
